hc_binary_counter: RTL and testbench
====================================

Name: hc_binary_counter

Overview:
- Parametrised, fully synchronous successor to the 12-stage ripple counter.
- Counts qualified edges on an external count pin, sampled in the `clk` domain.
- Adds the following over the fixed 12-bit counter:
  - selectable width and modulus;
  - edge polarity select;
  - input synchroniser;
  - up/down counting;
  - parallel load;
  - count enable;
  - terminal-count and carry outputs.
- Serves as the common counter core for the 74xx-style counter family (4040/4020/161/193-class pinout wrappers sit on top of it).

Parameters:
- WIDTH, 12, counter width in bits (1..32).
- MODULUS, 0, count modulus. 0 means natural 2^WIDTH wrap; otherwise counts 0..MODULUS-1 (2..2^WIDTH).
- EDGE, 0, active edge of cnt_in: 0 = falling, 1 = rising.
- SYNC_STAGES, 2, synchroniser flops on cnt_in (0..3). 0 samples cnt_in directly.

Ports:
- clk, in, 1, system clock; all state changes on its rising edge.
- rst, in, 1, synchronous active-high reset.
- cnt_in, in, 1, external count input; asynchronous to clk.
- clr, in, 1, synchronous counter clear (pin function); level-sensitive.
- load, in, 1, synchronous parallel load; level-sensitive.
- d_in, in, WIDTH, parallel load value.
- en, in, 1, count enable.
- up, in, 1, direction: 1 = up, 0 = down.
- q, out, WIDTH, counter value.
- tc, out, 1, terminal count (combinational from q and up).
- co, out, 1, registered carry/borrow pulse.

Behaviour:
- Reset (rst=1 at a clk edge):
  - q=0, co=0.
  - Synchroniser flops and edge history register are forced to the inactive level: 0 when EDGE=0, 1 when EDGE=1.
  - Consequence: a static cnt_in after reset never produces a count.
- Sampling: s = cnt_in delayed by SYNC_STAGES flops (s = cnt_in when 0). prev <= s every cycle, including during clr and load.
- Edge detection: edge = prev & ~s when EDGE=0; edge = ~prev & s when EDGE=1.
- Latency: q updates on the clk edge where edge=1. That is the first clk edge after the cnt_in transition plus SYNC_STAGES cycles.
- MAX = MODULUS-1, or 2^WIDTH-1 when MODULUS=0.
- Priority per cycle: rst > clr > load > (edge & en).
  - clr: q<=0, co<=0.
  - load: q<=d_in, co<=0.
  - edge & en & up:
    - q==MAX or q>MAX: q<=0, co<=1.
    - otherwise q<=q+1, co<=0.
  - edge & en & ~up:
    - q==0: q<=MAX, co<=1.
    - otherwise q<=q-1, co<=0.
  - Otherwise: q holds, co<=0.
- co is high for exactly one cycle per wrap.
- Edges arriving while en=0, clr=1, load=1 or rst=1 are discarded, not queued.
- A d_in value greater than MAX is loaded as-is.
- tc = up ? (q==MAX) : (q==0). tc is purely combinational and is not gated by en.
- A direction change takes effect on the next counted edge; no extra latency.
- All arithmetic is WIDTH bits, unsigned; no overflow beyond WIDTH.
- Max count rate: one count per 2 clk cycles (cnt_in high and low phases each at least 1 clk period, plus synchroniser setup). Narrower pulses may be missed; this is not an error.

Decomposition:
- Package hc_counter_pkg:
  - EDGE_FALL=0 and EDGE_RISE=1 constants;
  - a max_count(WIDTH, MODULUS) function;
  - a parameter-legality check function.
- One sub-module, hc_edge_detect: SYNC_STAGES synchroniser, prev register and polarity select. Outputs a single-cycle edge strobe.
- The counter/mux logic stays in hc_binary_counter.

Test Plan:
- Defaults, rst, then 5 falling edges on cnt_in (each phase 4 clk) -> q=5; each increment 3 clk after the fall; co stays 0.
- WIDTH=4, MODULUS=10, up=1, load d_in=8, then 2 edges -> q=9 with tc=1, then q=0 with co=1 for exactly one cycle and tc=0.
- WIDTH=4, MODULUS=0, up=0 from q=0, one edge -> q=15, co=1; toggle up=1, one edge -> q=0, co=1.
- EDGE=1, SYNC_STAGES=0: rst released with cnt_in held high -> no count; first rising edge -> q=1 on the next clk.
- Same-cycle clr=1, load=1, d_in=7 with a counted edge -> q=0. Next cycle load only -> q=7. Edge with en=0 -> q stays 7.
- rst asserted mid-count at q=0x5A3 with an edge in the synchroniser pipeline -> q=0 next cycle; no count after rst deasserts.

Source files
------------

// File: rtl/hc_counter_pkg.sv
// Shared constants and elaboration-time helpers for the hc counter family.
package hc_counter_pkg;

    localparam int unsigned EDGE_FALL = 0;
    localparam int unsigned EDGE_RISE = 1;

    // Highest value q may take: MODULUS-1, or all-ones for natural wrap.
    function automatic logic [31:0] max_count(input int unsigned width, input int unsigned modulus);
        logic [63:0] full;
        full = (64'd1 << width) - 64'd1;
        if (modulus == 0) begin
            return full[31:0];
        end
        return modulus - 32'd1;
    endfunction

    function automatic bit params_ok(input int unsigned width, input int unsigned modulus,
                                     input int unsigned edge_sel, input int unsigned sync_stages);
        logic [63:0] span;
        span = 64'd1 << width;
        if (width < 1 || width > 32) return 1'b0;
        if (modulus != 0 && (modulus < 2 || 64'(modulus) > span)) return 1'b0;
        if (edge_sel > EDGE_RISE) return 1'b0;
        if (sync_stages > 3) return 1'b0;
        return 1'b1;
    endfunction

endpackage

// File: rtl/hc_binary_counter_edge_detect.sv
// Synchronises cnt_in into clk and emits a one-cycle strobe on the selected edge.
module hc_edge_detect
    import hc_counter_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE        = EDGE_FALL
) (
    input  logic clk,
    input  logic rst,
    input  logic cnt_in,
    output logic strobe_c
);

    // Idle level of the pin; reset parks the pipeline here so a static input never counts.
    localparam logic INACTIVE = (EDGE == EDGE_RISE);

    logic s;
    logic prev;

    if (SYNC_STAGES == 0) begin : g_direct
        assign s = cnt_in;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] sync;

        always_ff @(posedge clk) begin
            if (rst) begin
                sync <= {SYNC_STAGES{INACTIVE}};
            end else begin
                sync <= (sync << 1) | SYNC_STAGES'(cnt_in);
            end
        end

        assign s = sync[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= INACTIVE;
        end else begin
            prev <= s;
        end
    end

    assign strobe_c = (EDGE == EDGE_RISE) ? (~prev & s) : (prev & ~s);

endmodule

// File: rtl/hc_binary_counter.sv
// Synchronous up/down modulus counter driven by qualified edges on cnt_in.
module hc_binary_counter
    import hc_counter_pkg::*;
#(
    parameter int unsigned WIDTH       = 12,
    parameter int unsigned MODULUS     = 0,
    parameter int unsigned EDGE        = EDGE_FALL,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cnt_in,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d_in,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             co
);

    if (!params_ok(WIDTH, MODULUS, EDGE, SYNC_STAGES)) begin : g_bad_params
        $error("hc_binary_counter: illegal WIDTH/MODULUS/EDGE/SYNC_STAGES combination");
    end

    localparam logic [WIDTH-1:0] MAX = WIDTH'(max_count(WIDTH, MODULUS));

    logic strobe_c;

    hc_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES),
        .EDGE       (EDGE)
    ) u_edge (
        .clk     (clk),
        .rst     (rst),
        .cnt_in  (cnt_in),
        .strobe_c(strobe_c)
    );

    // Values above MAX (only reachable via load) wrap to 0 on the next up count.
    always_ff @(posedge clk) begin
        if (rst) begin
            q  <= '0;
            co <= 1'b0;
        end else if (clr) begin
            q  <= '0;
            co <= 1'b0;
        end else if (load) begin
            q  <= d_in;
            co <= 1'b0;
        end else if (strobe_c && en) begin
            if (up) begin
                if (q >= MAX) begin
                    q  <= '0;
                    co <= 1'b1;
                end else begin
                    q  <= q + WIDTH'(1);
                    co <= 1'b0;
                end
            end else begin
                if (q == '0) begin
                    q  <= MAX;
                    co <= 1'b1;
                end else begin
                    q  <= q - WIDTH'(1);
                    co <= 1'b0;
                end
            end
        end else begin
            co <= 1'b0;
        end
    end

    assign tc = up ? (q == MAX) : (q == '0);

endmodule

// File: tb/tb_hc_binary_counter.sv
// Directed bench for hc_binary_counter across four parameter sets sharing one stimulus bus.
module tb_hc_binary_counter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cnt_in;
    logic        clr;
    logic        load;
    logic [11:0] d_in;
    logic        en;
    logic        up;

    logic [11:0] q0, q3;
    logic [3:0]  q1, q2;
    logic        tc0, tc1, tc2, tc3;
    logic        co0, co1, co2, co3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Defaults: 12-bit natural wrap, falling edge, 2 sync stages.
    hc_binary_counter u0 (
        .clk(clk), .rst(rst), .cnt_in(cnt_in), .clr(clr), .load(load), .d_in(d_in),
        .en(en), .up(up), .q(q0), .tc(tc0), .co(co0)
    );

    hc_binary_counter #(.WIDTH(4), .MODULUS(10)) u1 (
        .clk(clk), .rst(rst), .cnt_in(cnt_in), .clr(clr), .load(load), .d_in(d_in[3:0]),
        .en(en), .up(up), .q(q1), .tc(tc1), .co(co1)
    );

    hc_binary_counter #(.WIDTH(4), .MODULUS(0)) u2 (
        .clk(clk), .rst(rst), .cnt_in(cnt_in), .clr(clr), .load(load), .d_in(d_in[3:0]),
        .en(en), .up(up), .q(q2), .tc(tc2), .co(co2)
    );

    hc_binary_counter #(.EDGE(1), .SYNC_STAGES(0)) u3 (
        .clk(clk), .rst(rst), .cnt_in(cnt_in), .clr(clr), .load(load), .d_in(d_in),
        .en(en), .up(up), .q(q3), .tc(tc3), .co(co3)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1; cnt_in = 1'b1; clr = 1'b0; load = 1'b0;
        d_in = '0; en = 1'b1; up = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic high_phase();
        cnt_in = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (q0 !== 12'd0 || co0 !== 1'b0) begin
            bad++; $display("FAIL reset_u0: q=%0d co=%0b want q=0 co=0", q0, co0);
        end
        total++;
        if (tc0 !== 1'b0) begin
            bad++; $display("FAIL reset_tc_u0: tc=%0b want 0", tc0);
        end
        total++;
        if (q1 !== 4'd0 || q2 !== 4'd0 || q3 !== 12'd0) begin
            bad++; $display("FAIL reset_others: q1=%0d q2=%0d q3=%0d want 0", q1, q2, q3);
        end
    endtask

    task automatic test_count_up();
        do_reset();
        high_phase();
        for (int i = 1; i <= 5; i++) begin
            cnt_in = 1'b0;
            repeat (2) tick();
            total++;
            if (q0 !== 12'(i - 1)) begin
                bad++; $display("FAIL count_early_%0d: q=%0d want %0d", i, q0, i - 1);
            end
            tick();
            total++;
            if (q0 !== 12'(i) || co0 !== 1'b0) begin
                bad++; $display("FAIL count_step_%0d: q=%0d co=%0b want q=%0d co=0", i, q0, co0, i);
            end
            tick();
            high_phase();
        end
        total++;
        if (q0 !== 12'd5 || tc0 !== 1'b0) begin
            bad++; $display("FAIL count_final: q=%0d tc=%0b want q=5 tc=0", q0, tc0);
        end
    endtask

    task automatic test_modulus();
        do_reset();
        high_phase();
        load = 1'b1; d_in = 12'd8;
        tick();
        load = 1'b0;
        total++;
        if (q1 !== 4'd8 || tc1 !== 1'b0) begin
            bad++; $display("FAIL mod_load: q=%0d tc=%0b want q=8 tc=0", q1, tc1);
        end
        cnt_in = 1'b0;
        repeat (3) tick();
        total++;
        if (q1 !== 4'd9 || tc1 !== 1'b1 || co1 !== 1'b0) begin
            bad++; $display("FAIL mod_nine: q=%0d tc=%0b co=%0b want 9 1 0", q1, tc1, co1);
        end
        tick();
        high_phase();
        cnt_in = 1'b0;
        repeat (3) tick();
        total++;
        if (q1 !== 4'd0 || co1 !== 1'b1 || tc1 !== 1'b0) begin
            bad++; $display("FAIL mod_wrap: q=%0d co=%0b tc=%0b want 0 1 0", q1, co1, tc1);
        end
        tick();
        total++;
        if (q1 !== 4'd0 || co1 !== 1'b0) begin
            bad++; $display("FAIL mod_co_pulse: q=%0d co=%0b want 0 0", q1, co1);
        end
    endtask

    task automatic test_down();
        do_reset();
        up = 1'b0;
        high_phase();
        total++;
        if (tc2 !== 1'b1) begin
            bad++; $display("FAIL down_tc_zero: tc=%0b want 1", tc2);
        end
        cnt_in = 1'b0;
        repeat (3) tick();
        total++;
        if (q2 !== 4'd15 || co2 !== 1'b1 || tc2 !== 1'b0) begin
            bad++; $display("FAIL down_borrow: q=%0d co=%0b tc=%0b want 15 1 0", q2, co2, tc2);
        end
        tick();
        total++;
        if (co2 !== 1'b0) begin
            bad++; $display("FAIL down_co_pulse: co=%0b want 0", co2);
        end
        up = 1'b1;
        high_phase();
        total++;
        if (tc2 !== 1'b1) begin
            bad++; $display("FAIL dir_tc_max: tc=%0b want 1", tc2);
        end
        cnt_in = 1'b0;
        repeat (3) tick();
        total++;
        if (q2 !== 4'd0 || co2 !== 1'b1) begin
            bad++; $display("FAIL dir_up_wrap: q=%0d co=%0b want 0 1", q2, co2);
        end
        tick();
    endtask

    task automatic test_rise_nosync();
        do_reset();
        repeat (4) tick();
        total++;
        if (q3 !== 12'd0) begin
            bad++; $display("FAIL rise_static_high: q=%0d want 0", q3);
        end
        cnt_in = 1'b0;
        repeat (2) tick();
        total++;
        if (q3 !== 12'd0) begin
            bad++; $display("FAIL rise_fall_ignored: q=%0d want 0", q3);
        end
        cnt_in = 1'b1;
        tick();
        total++;
        if (q3 !== 12'd1) begin
            bad++; $display("FAIL rise_first: q=%0d want 1", q3);
        end
        repeat (3) tick();
        total++;
        if (q3 !== 12'd1) begin
            bad++; $display("FAIL rise_hold: q=%0d want 1", q3);
        end
    endtask

    task automatic test_priority();
        do_reset();
        high_phase();
        cnt_in = 1'b0;
        repeat (3) tick();
        total++;
        if (q0 !== 12'd1) begin
            bad++; $display("FAIL prio_setup: q=%0d want 1", q0);
        end
        tick();
        high_phase();
        cnt_in = 1'b0;
        repeat (2) tick();
        clr = 1'b1; load = 1'b1; d_in = 12'd7;
        tick();
        total++;
        if (q0 !== 12'd0 || co0 !== 1'b0) begin
            bad++; $display("FAIL prio_clr: q=%0d co=%0b want 0 0", q0, co0);
        end
        clr = 1'b0;
        tick();
        load = 1'b0;
        total++;
        if (q0 !== 12'd7) begin
            bad++; $display("FAIL prio_load: q=%0d want 7", q0);
        end
        high_phase();
        en = 1'b0;
        cnt_in = 1'b0;
        repeat (4) tick();
        total++;
        if (q0 !== 12'd7 || co0 !== 1'b0) begin
            bad++; $display("FAIL prio_en_off: q=%0d co=%0b want 7 0", q0, co0);
        end
        en = 1'b1;
        repeat (4) tick();
        total++;
        if (q0 !== 12'd7) begin
            bad++; $display("FAIL prio_not_queued: q=%0d want 7", q0);
        end
    endtask

    task automatic test_rst_midcount();
        do_reset();
        high_phase();
        load = 1'b1; d_in = 12'h5A3;
        tick();
        load = 1'b0;
        total++;
        if (q0 !== 12'h5A3) begin
            bad++; $display("FAIL rst_mid_load: q=%h want 5a3", q0);
        end
        cnt_in = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        total++;
        if (q0 !== 12'd0) begin
            bad++; $display("FAIL rst_mid_clear: q=%h want 0", q0);
        end
        rst = 1'b0;
        repeat (6) tick();
        total++;
        if (q0 !== 12'd0 || co0 !== 1'b0) begin
            bad++; $display("FAIL rst_mid_no_count: q=%h co=%0b want 0 0", q0, co0);
        end
        high_phase();
        total++;
        if (q0 !== 12'd0) begin
            bad++; $display("FAIL rst_mid_rise: q=%h want 0", q0);
        end
    endtask

    initial begin
        rst = 1'b1; cnt_in = 1'b1; clr = 1'b0; load = 1'b0;
        d_in = '0; en = 1'b1; up = 1'b1;
        test_reset();
        test_count_up();
        test_modulus();
        test_down();
        test_rise_nosync();
        test_priority();
        test_rst_midcount();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
